// File: rtl/pie_pkg.sv
// Shared definitions for the PIE (reader-to-tag) symbol decoder.
package pie_pkg;

    // Decoder FSM states
    typedef enum logic [2:0] {
        StIdle,
        StTari,
        StRtcal,
        StSync,
        StData
    } pie_state_e;

    // Default timing windows, in 1.92 MHz cycles
    localparam int unsigned PIE_DELIM_MIN = 21;
    localparam int unsigned PIE_DELIM_MAX = 27;
    localparam int unsigned PIE_TARI_MIN  = 10;
    localparam int unsigned PIE_TARI_MAX  = 50;

    // End-of-frame timeout is this many RTcal of CW
    localparam int unsigned PIE_TMO_MUL   = 4;
    // Longest accepted TRcal, in RTcal units
    localparam int unsigned PIE_TRCAL_MUL = 3;

endpackage

// File: rtl/rd_sync.sv
// Envelope input conditioning: 2-flop synchroniser, registered level and
// registered rise/fall strobes. Everything resets high (idle CW).
module rd_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_rd,
    output logic o_lvl,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_lvl;
    logic r_rise;
    logic r_fall;

    // Synchronise the pin and derive edges from the registered level, so the
    // strobes line up with o_lvl and a rise and fall never share a cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_lvl  <= 1'b1;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_meta <= i_rd;
            r_sync <= r_meta;
            r_lvl  <= r_sync;
            r_rise <= r_sync & ~r_lvl;
            r_fall <= ~r_sync & r_lvl;
        end
    end

    assign o_lvl  = r_lvl;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/pie_decoder.sv
// PIE symbol decoder: delimiter detection, Tari/RTcal/TRcal measurement,
// data slicing and frame start/end/error signalling.
module pie_decoder
    import pie_pkg::*;
#(
    parameter int unsigned CNT_W     = 12,
    parameter int unsigned DELIM_MIN = PIE_DELIM_MIN,
    parameter int unsigned DELIM_MAX = PIE_DELIM_MAX,
    parameter int unsigned TARI_MIN  = PIE_TARI_MIN,
    parameter int unsigned TARI_MAX  = PIE_TARI_MAX
) (
    input  logic             clk_1_92m,
    input  logic             rst_n,
    input  logic             rd_data,
    output logic             bit_data,
    output logic             bit_vld,
    output logic             frame_start,
    output logic             frame_end,
    output logic             frame_err,
    output logic             trcal_vld,
    output logic [CNT_W-1:0] tari,
    output logic [CNT_W-1:0] rtcal,
    output logic [CNT_W-1:0] trcal
);

    // Products are formed two bits wider than the counter so they never wrap
    localparam int unsigned      XW      = CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] L_DMIN  = CNT_W'(DELIM_MIN);
    localparam logic [CNT_W-1:0] L_DMAX  = CNT_W'(DELIM_MAX);
    localparam logic [CNT_W-1:0] L_TMIN  = CNT_W'(TARI_MIN);
    localparam logic [CNT_W-1:0] L_TMAX  = CNT_W'(TARI_MAX);
    localparam logic [XW-1:0]    TMO_K   = XW'(PIE_TMO_MUL);
    localparam logic [XW-1:0]    TRC_K   = XW'(PIE_TRCAL_MUL);

    logic w_lvl;
    logic w_rise;
    logic w_fall;

    logic [CNT_W-1:0] r_ivl;
    logic [CNT_W-1:0] r_low;

    pie_state_e       r_state;
    logic             r_bit;
    logic             r_bit_vld;
    logic             r_start;
    logic             r_end;
    logic             r_err;
    logic             r_trcal_vld;
    logic [CNT_W-1:0] r_tari;
    logic [CNT_W-1:0] r_rtcal;
    logic [CNT_W-1:0] r_trcal;

    logic          w_ivl_sat;
    logic [XW-1:0] w_ivl_x;
    logic [XW-1:0] w_tari_x2;
    logic [XW-1:0] w_tari_x4;
    logic [XW-1:0] w_rtcal_x;
    logic [XW-1:0] w_rtcal_x3;
    logic [XW-1:0] w_rtcal_x4;
    logic          w_delim_ok;
    logic          w_tari_ok;
    logic          w_rtcal_ok;
    logic          w_trcal_ok;
    logic          w_sync_bit;
    logic          w_bit;
    logic          w_low_viol;
    logic          w_tmo;
    logic          w_in_frame;

    rd_sync u_rd_sync (
        .i_clk   (clk_1_92m),
        .i_rst_n (rst_n),
        .i_rd    (rd_data),
        .o_lvl   (w_lvl),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_ivl_sat  = (r_ivl == CNT_MAX);
    assign w_ivl_x    = XW'(r_ivl);
    assign w_tari_x2  = XW'(r_tari) << 1;
    assign w_tari_x4  = XW'(r_tari) * TMO_K;
    assign w_rtcal_x  = XW'(r_rtcal);
    assign w_rtcal_x3 = XW'(r_rtcal) * TRC_K;
    assign w_rtcal_x4 = XW'(r_rtcal) * TMO_K;

    // A saturated count fails every window, including the delimiter one
    // (r_low saturated is always above DELIM_MAX).
    assign w_delim_ok = (r_low >= L_DMIN) && (r_low <= L_DMAX);
    assign w_tari_ok  = !w_ivl_sat && (r_ivl >= L_TMIN) && (r_ivl <= L_TMAX);
    assign w_rtcal_ok = !w_ivl_sat && (w_ivl_x > w_tari_x2) && (w_ivl_x < w_tari_x4);
    assign w_trcal_ok = !w_ivl_sat && (w_ivl_x > w_rtcal_x) && (w_ivl_x <= w_rtcal_x3);
    assign w_sync_bit = !w_ivl_sat && (w_ivl_x <= w_rtcal_x);
    assign w_bit      = (r_ivl >= (r_rtcal >> 1));

    // r_low still holds the previous pulse on the fall cycle, hence !w_fall.
    // DELIM_MIN <= DELIM_MAX+1, so this also covers the stuck-low case.
    assign w_low_viol = !w_lvl && !w_fall && (r_low >= L_DMIN);

    // Fires one cycle early so frame_end lands as the counter passes 4*RTcal
    assign w_tmo      = w_lvl && !w_rise && (w_ivl_x >= w_rtcal_x4);

    assign w_in_frame = (r_state != StIdle);

    // Interval (rise to rise) and low-time (fall to rise) counters, saturating
    always_ff @(posedge clk_1_92m or negedge rst_n) begin
        if (!rst_n) begin
            r_ivl <= '0;
            r_low <= '0;
        end else begin
            if (w_rise) begin
                r_ivl <= CNT_W'(1);
            end else if (!w_ivl_sat) begin
                r_ivl <= r_ivl + 1'b1;
            end
            if (w_fall) begin
                r_low <= CNT_W'(1);
            end else if (!w_lvl && (r_low != CNT_MAX)) begin
                r_low <= r_low + 1'b1;
            end
        end
    end

    // Frame FSM with registered pulses and calibration registers
    always_ff @(posedge clk_1_92m or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_bit       <= 1'b0;
            r_bit_vld   <= 1'b0;
            r_start     <= 1'b0;
            r_end       <= 1'b0;
            r_err       <= 1'b0;
            r_trcal_vld <= 1'b0;
            r_tari      <= '0;
            r_rtcal     <= '0;
            r_trcal     <= '0;
        end else begin
            r_bit_vld <= 1'b0;
            r_start   <= 1'b0;
            r_end     <= 1'b0;
            r_err     <= 1'b0;

            if (w_in_frame && w_low_viol) begin
                // Long low inside a frame: flag once, then let IDLE judge the
                // following rise as a possible new delimiter.
                r_err   <= 1'b1;
                r_state <= StIdle;
            end else if (((r_state == StSync) || (r_state == StData)) && w_tmo) begin
                r_end   <= 1'b1;
                r_state <= StIdle;
            end else if (w_rise) begin
                case (r_state)
                    StIdle: begin
                        if (w_delim_ok) begin
                            r_state <= StTari;
                        end
                    end
                    StTari: begin
                        if (w_tari_ok) begin
                            r_tari  <= r_ivl;
                            r_state <= StRtcal;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= StIdle;
                        end
                    end
                    StRtcal: begin
                        if (w_rtcal_ok) begin
                            r_rtcal     <= r_ivl;
                            r_start     <= 1'b1;
                            r_trcal_vld <= 1'b0;
                            r_state     <= StSync;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= StIdle;
                        end
                    end
                    StSync: begin
                        if (w_trcal_ok) begin
                            r_trcal     <= r_ivl;
                            r_trcal_vld <= 1'b1;
                            r_state     <= StData;
                        end else if (w_sync_bit) begin
                            // Frame-sync: no TRcal, this symbol is already data
                            r_bit     <= w_bit;
                            r_bit_vld <= 1'b1;
                            r_state   <= StData;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= StIdle;
                        end
                    end
                    StData: begin
                        if (!w_ivl_sat) begin
                            r_bit     <= w_bit;
                            r_bit_vld <= 1'b1;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= StIdle;
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

    assign bit_data    = r_bit;
    assign bit_vld     = r_bit_vld;
    assign frame_start = r_start;
    assign frame_end   = r_end;
    assign frame_err   = r_err;
    assign trcal_vld   = r_trcal_vld;
    assign tari        = r_tari;
    assign rtcal       = r_rtcal;
    assign trcal       = r_trcal;

endmodule
